// File: rtl/player_motion.sv
// Per-frame player car kinematics: speed, lateral position, odometer and crash countdown.
// Updates on the clock edge that sees the vsync falling edge; frame_tick follows one cycle later; no backpressure.
module player_motion #(
  parameter int SPEED_MAX    = 200,
  parameter int ACCEL        = 2,
  parameter int BRAKE        = 8,
  parameter int DRAG         = 1,
  parameter int X_MIN        = 64,
  parameter int X_MAX        = 575,
  parameter int X_INIT       = 320,
  parameter int CRASH_SPEED  = 100,
  parameter int CRASH_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset_h,
  input  logic [7:0]  keycode,
  input  logic        vga_vs,
  output logic [7:0]  speed,
  output logic [9:0]  car_x,
  output logic [15:0] odometer,
  output logic        crashed,
  output logic        frame_tick
);

  localparam logic [7:0]  KEY_W     = 8'h1A;
  localparam logic [7:0]  KEY_S     = 8'h16;
  localparam logic [7:0]  KEY_A     = 8'h04;
  localparam logic [7:0]  KEY_D     = 8'h07;
  localparam logic [8:0]  SMAX_9    = 9'(SPEED_MAX);
  localparam logic [8:0]  ACCEL_9   = 9'(ACCEL);
  localparam logic [8:0]  BRAKE_9   = 9'(BRAKE);
  localparam logic [8:0]  DRAG_9    = 9'(DRAG);
  localparam logic [10:0] XMIN_11   = 11'(X_MIN);
  localparam logic [10:0] XMAX_11   = 11'(X_MAX);
  localparam logic [9:0]  XMIN_10   = 10'(X_MIN);
  localparam logic [9:0]  XMAX_10   = 10'(X_MAX);
  localparam logic [9:0]  XINIT_10  = 10'(X_INIT);
  localparam logic [7:0]  CRASH_8   = 8'(CRASH_SPEED);
  localparam logic [15:0] CRASH_CNT = 16'(CRASH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CRASH
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  speed_q, speed_d;
  logic [9:0]  car_x_q, car_x_d;
  logic [15:0] odo_q, odo_d;
  logic        crashed_q, crashed_d;
  logic        tick_q, tick_d;
  logic [15:0] crash_cnt_q, crash_cnt_d;
  logic        vs_dly_q, vs_dly_d;

  logic        frame_ev;
  logic [9:0]  step;
  logic [8:0]  spd_ext;
  logic [8:0]  spd_acc;
  logic [8:0]  spd_next;
  logic [10:0] x_ext;
  logic [10:0] step_ext;
  logic [9:0]  x_next;
  logic        wall_hit;

  assign frame_ev = vs_dly_q & ~vga_vs;
  assign spd_ext  = {1'b0, speed_q};
  assign spd_acc  = spd_ext + ACCEL_9;
  assign x_ext    = {1'b0, car_x_q};
  assign step_ext = {1'b0, step};

  // Steering step grows with speed: 1 + speed/64, zero when stopped.
  always_comb begin
    step = '0;
    if (speed_q != 8'd0) begin
      step = {8'd0, speed_q[7:6]} + 10'd1;
    end
  end

  always_comb begin
    spd_next = spd_ext;
    if (keycode == KEY_W) begin
      spd_next = (spd_acc > SMAX_9) ? SMAX_9 : spd_acc;
    end else if (keycode == KEY_S) begin
      spd_next = (spd_ext < BRAKE_9) ? 9'd0 : spd_ext - BRAKE_9;
    end else begin
      spd_next = (spd_ext < DRAG_9) ? 9'd0 : spd_ext - DRAG_9;
    end
  end

  // Compare in 11 bits so neither the subtract nor the add can wrap.
  always_comb begin
    x_next   = car_x_q;
    wall_hit = 1'b0;
    if (keycode == KEY_A) begin
      if (x_ext < XMIN_11 + step_ext) begin
        x_next   = XMIN_10;
        wall_hit = 1'b1;
      end else begin
        x_next = car_x_q - step;
      end
    end else if (keycode == KEY_D) begin
      if (x_ext + step_ext > XMAX_11) begin
        x_next   = XMAX_10;
        wall_hit = 1'b1;
      end else begin
        x_next = car_x_q + step;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    car_x_d     = car_x_q;
    odo_d       = odo_q;
    crash_cnt_d = crash_cnt_q;
    tick_d      = 1'b0;
    vs_dly_d    = vga_vs;
    if (frame_ev) begin
      tick_d = 1'b1;
      if (state_q == ST_CRASH) begin
        if (crash_cnt_q == 16'd0) begin
          car_x_d = XINIT_10;
          state_d = ST_IDLE;
        end else begin
          crash_cnt_d = crash_cnt_q - 16'd1;
        end
      end else begin
        odo_d   = odo_q + {8'd0, speed_q};
        car_x_d = x_next;
        if (wall_hit && (speed_q >= CRASH_8)) begin
          state_d     = ST_CRASH;
          speed_d     = 8'd0;
          crash_cnt_d = CRASH_CNT;
        end else begin
          speed_d = spd_next[7:0];
          state_d = (spd_next != 9'd0) ? ST_DRIVE : ST_IDLE;
        end
      end
    end
    crashed_d = (state_d == ST_CRASH);
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q     <= ST_IDLE;
      speed_q     <= 8'd0;
      car_x_q     <= XINIT_10;
      odo_q       <= 16'd0;
      crashed_q   <= 1'b0;
      tick_q      <= 1'b0;
      crash_cnt_q <= 16'd0;
      vs_dly_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      car_x_q     <= car_x_d;
      odo_q       <= odo_d;
      crashed_q   <= crashed_d;
      tick_q      <= tick_d;
      crash_cnt_q <= crash_cnt_d;
      vs_dly_q    <= vs_dly_d;
    end
  end

  assign speed      = speed_q;
  assign car_x      = car_x_q;
  assign odometer   = odo_q;
  assign crashed    = crashed_q;
  assign frame_tick = frame_tick_w();

  function automatic logic frame_tick_w();
    return tick_q;
  endfunction

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: a behavioural model queues the expected outputs of every frame,
// and a negedge monitor pops and compares them whenever frame_tick fires.
module tb_player_motion;

  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_S = 8'h16;
  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_D = 8'h07;

  logic        clk = 1'b0;
  logic        reset_h;
  logic        vga_vs;
  logic [7:0]  keycode;
  logic [7:0]  speed;
  logic [9:0]  car_x;
  logic [15:0] odometer;
  logic        crashed;
  logic        frame_tick;

  player_motion dut (
    .Clk        (clk),
    .Reset_h    (reset_h),
    .keycode    (keycode),
    .vga_vs     (vga_vs),
    .speed      (speed),
    .car_x      (car_x),
    .odometer   (odometer),
    .crashed    (crashed),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int speed;
    int x;
    int odo;
    int crashed;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_speed, m_x, m_odo, m_state, m_cnt;
  int   ticks_seen = 0;
  int   prev_odo = 0;
  int   t0;
  logic prev_tick = 1'b0;
  logic wrap_seen = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_speed = 0;
    m_x     = 320;
    m_odo   = 0;
    m_state = 0;
    m_cnt   = 0;
    sb_q.delete();
  endtask

  // Behavioural model of one frame update; state 2 is the crash countdown.
  task automatic mdl_frame(input logic [7:0] k);
    int   s, ns, nx, step;
    bit   hit;
    exp_t e;
    s   = m_speed;
    ns  = s;
    nx  = m_x;
    hit = 0;
    if (m_state == 2) begin
      if (m_cnt == 0) begin
        m_x     = 320;
        m_state = 0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else begin
      m_odo = (m_odo + s) % 65536;
      if (k == K_W)      ns = (s + 2 > 200) ? 200 : s + 2;
      else if (k == K_S) ns = (s < 8) ? 0 : s - 8;
      else               ns = (s < 1) ? 0 : s - 1;
      step = (s == 0) ? 0 : 1 + s / 64;
      if (k == K_A) begin
        nx = m_x - step;
        if (nx < 64) begin nx = 64; hit = 1; end
      end else if (k == K_D) begin
        nx = m_x + step;
        if (nx > 575) begin nx = 575; hit = 1; end
      end
      m_x = nx;
      if (hit && s >= 100) begin
        m_state = 2;
        m_speed = 0;
        m_cnt   = 59;
      end else begin
        m_speed = ns;
        m_state = (ns > 0) ? 1 : 0;
      end
    end
    e.speed   = m_speed;
    e.x       = m_x;
    e.odo     = m_odo;
    e.crashed = (m_state == 2) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  // Called at #1 after a posedge; returns at #1 after a posedge.
  task automatic frame(input logic [7:0] k);
    keycode = k;
    mdl_frame(k);
    vga_vs = 1'b0;
    @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (frame_tick) begin
      ticks_seen++;
      chk("tick_width", int'(prev_tick), 0);
      chk("tick_expected", int'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("speed", int'(speed), mon_e.speed);
        chk("car_x", int'(car_x), mon_e.x);
        chk("odometer", int'(odometer), mon_e.odo);
        chk("crashed", int'(crashed), mon_e.crashed);
      end
      if (int'(odometer) < prev_odo) wrap_seen = 1'b1;
      prev_odo = int'(odometer);
    end
    prev_tick = frame_tick;
  end

  initial begin
    reset_h = 1'b1;
    vga_vs  = 1'b1;
    keycode = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_h = 1'b0;
    mdl_reset();
    @(negedge clk);
    chk("rst_speed", int'(speed), 0);
    chk("rst_x", int'(car_x), 320);
    chk("rst_odo", int'(odometer), 0);
    chk("rst_crashed", int'(crashed), 0);
    chk("rst_tick", int'(frame_tick), 0);
    @(posedge clk);
    #1;

    repeat (10) frame(K_W);
    chk("acc_speed", int'(speed), 20);
    chk("acc_odo", int'(odometer), 90);
    chk("acc_x", int'(car_x), 320);
    chk("acc_ticks", ticks_seen, 10);

    repeat (110) frame(K_W);
    chk("sat_speed", int'(speed), 200);
    repeat (340) frame(K_W);
    chk("odo_wrap", int'(wrap_seen), 1);
    repeat (195) frame(8'h00);
    chk("drag_speed", int'(speed), 5);
    frame(K_S);
    chk("brake_floor", int'(speed), 0);
    chk("brake_crashed", int'(crashed), 0);

    for (int i = 0; i < 2000 && m_x < 575; i++) frame((m_speed < 50) ? K_W : K_D);
    repeat (3) frame(K_D);
    chk("soft_wall_x", int'(car_x), 575);
    chk("soft_wall_crashed", int'(crashed), 0);

    for (int i = 0; i < 100 && m_x > 560; i++) frame((m_speed < 50) ? K_W : K_A);
    repeat (80) frame(K_W);
    chk("pre_crash_speed", int'(speed), 200);
    for (int i = 0; i < 20 && m_state != 2; i++) frame(K_D);
    chk("crash_flag", int'(crashed), 1);
    chk("crash_x", int'(car_x), 575);
    chk("crash_speed", int'(speed), 0);
    repeat (59) frame(K_W);
    chk("crash_hold", int'(crashed), 1);
    chk("crash_hold_speed", int'(speed), 0);
    frame(K_W);
    chk("crash_exit", int'(crashed), 0);
    chk("crash_exit_x", int'(car_x), 320);

    for (int i = 0; i < 3000 && m_x > 64; i++) frame((m_speed < 50) ? K_W : K_A);
    frame(K_A);
    chk("left_wall_x", int'(car_x), 64);
    chk("left_wall_crashed", int'(crashed), 0);

    repeat (60) frame(K_W);
    frame(K_A);
    chk("crash2_flag", int'(crashed), 1);
    repeat (5) frame(K_W);
    keycode = K_W;
    vga_vs  = 1'b0;
    reset_h = 1'b1;
    @(posedge clk);
    #1 reset_h = 1'b0;
    vga_vs = 1'b1;
    mdl_reset();
    @(negedge clk);
    chk("mid_rst_speed", int'(speed), 0);
    chk("mid_rst_x", int'(car_x), 320);
    chk("mid_rst_odo", int'(odometer), 0);
    chk("mid_rst_crashed", int'(crashed), 0);
    chk("mid_rst_tick", int'(frame_tick), 0);
    @(posedge clk);
    #1;

    t0      = ticks_seen;
    keycode = K_W;
    mdl_frame(K_W);
    vga_vs = 1'b0;
    repeat (1000) @(posedge clk);
    #1 vga_vs = 1'b1;
    mdl_frame(K_W);
    @(posedge clk);
    #1 vga_vs = 1'b0;
    repeat (5) @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("vs_events", ticks_seen - t0, 2);
    chk("vs_speed", int'(speed), 4);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_motion.md
# player_motion

Per-frame player car kinematics for Pole Position. Consumes the 8-bit USB HID keycode exported by the SoC and the VGA vertical sync. Once per frame it updates car speed, lateral position, odometer (road scroll offset) and a crash state. Its outputs feed the road and sprite renderer and the HEX/LED status path.

## Interface
Parameters:
- SPEED_MAX, 200: speed saturation value (≤255)
- ACCEL, 2: speed increase per frame while accelerating
- BRAKE, 8: speed decrease per frame while braking
- DRAG, 1: speed decrease per frame with no throttle key
- X_MIN, 64: leftmost legal car_x
- X_MAX, 575: rightmost legal car_x
- X_INIT, 320: car_x after reset and after a crash
- CRASH_SPEED, 100: minimum pre-update speed that turns a wall hit into a crash
- CRASH_FRAMES, 60: frames spent in CRASH

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_h  in  1  synchronous, active-high reset
- keycode  in  8  HID usage code; 0x1A = W accelerate, 0x16 = S brake, 0x04 = A left, 0x07 = D right, anything else = no key
- vga_vs  in  1  VGA vsync, active low, synchronous to Clk
- speed  out  8  current speed
- car_x  out  10  car screen x
- odometer  out  16  accumulated distance, wraps modulo 2^16
- crashed  out  1  high while in CRASH
- frame_tick  out  1  one-cycle pulse after every frame update

## Operation
- Frame event: the falling edge of vga_vs, detected as vs_d==1 && vga_vs==0, where vs_d is vga_vs registered.
- All motion registers change only on a frame event.
- States:
  - IDLE: speed==0.
  - DRIVE: speed>0.
  - CRASH: counting out a crash.
- Each frame event in IDLE or DRIVE:
  - Let s be the pre-update speed.
  - odometer += s, 16-bit wrap.
  - Speed update:
    - W: min(s+ACCEL, SPEED_MAX).
    - S: max(s−BRAKE, 0).
    - Any other keycode: max(s−DRAG, 0).
    - Arithmetic uses 9 bits, so it never wraps.
  - Steering step: 0 if s==0, else 1+(s>>6).
    - A subtracts the step from car_x.
    - D adds the step to car_x.
    - Any other keycode leaves car_x unchanged.
  - Wall hit: car_x−step < X_MIN, or car_x+step > X_MAX. On a wall hit car_x clamps to the bound.
  - If a wall hit occurs and s ≥ CRASH_SPEED:
    - Go to CRASH.
    - speed := 0.
    - crash_cnt := CRASH_FRAMES−1.
    - Crash takes priority over the speed update.
  - Otherwise, next state is DRIVE if the new speed > 0, else IDLE.
- CRASH:
  - keycode is ignored; speed stays 0; odometer is frozen; crashed=1.
  - On each frame event: if crash_cnt==0, car_x := X_INIT and go to IDLE; else crash_cnt−1.
- A single keycode means W and A cannot both be pressed. Steering keys never change speed except through DRAG.
- Reset values, on the edge where Reset_h=1:
  - state=IDLE, speed=0, car_x=X_INIT, odometer=0, crashed=0, frame_tick=0, crash_cnt=0, vs_d=1.
- Reset overrides a simultaneous frame event, including mid-crash.

## Timing
- Clock edge k, where vs_d==1 and vga_vs==0 are sampled: speed, car_x, odometer, state and crashed take their new values.
- frame_tick is high for exactly the cycle following edge k.
- All outputs are registered; frame_tick never precedes the updated values.
- Frame events are one per falling edge:
  - vga_vs held low or held high produces no further events.
  - A one-cycle low pulse on vga_vs produces exactly one event.
- Latency from keycode change to effect: the next frame event. keycode is sampled only at edge k.

## Test plan
- Accelerate from reset: reset, keycode=0x1A for 10 frames -> speed=20, odometer=90 (0+2+…+18), car_x=320, state DRIVE, 10 frame_tick pulses each 1 cycle wide.
- Saturation and decel floor: 0x1A for 120 frames -> speed reaches 200 at frame 100 and holds. Then 0x00 -> speed drops 1/frame. Then with speed=5, 0x16 -> speed=0, no wrap, state IDLE.
- Steering and soft wall: drive to speed=50, hold 0x07 -> step 1 while s<64. car_x clamps at 575 with crashed=0 and no state change other than drag.
- Crash: drive to speed=200, hold 0x07 -> step 4 until s<192. On the frame where car_x+step>575 (with s≥100): car_x=575, speed=0, crashed=1. keycode=0x1A is ignored for 60 frames. On the 60th frame event car_x=320, crashed=0, state IDLE.
- Reset mid-crash: assert Reset_h during CRASH, coincident with a frame event -> next cycle all reset values; crashed=0, car_x=320, frame_tick=0.
- vsync robustness: vga_vs held low 1000 cycles, then a 1-cycle high pulse, then low -> exactly one update. odometer wrap: preload near 65535 by driving at 200 -> wraps modulo 65536.
